// File: rtl/neuron_feeder_if.sv
// Load, control and neuron-facing signals of neuron_feeder in one bundle.
// The master side loads vectors and starts runs; the slave side is the feeder.
interface neuron_feeder_if #(
    parameter int N     = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic                 load_we;
    logic [AW-1:0]        load_addr;
    logic signed [N-1:0]  load_w;
    logic signed [N-1:0]  load_x;
    logic                 start;
    logic [LW-1:0]        len;
    logic                 hold;
    logic signed [N-1:0]  W_out;
    logic signed [N-1:0]  X_out;
    logic                 en_out;
    logic                 acc_clr_n;
    logic                 busy;
    logic                 done;

    modport master (
        output load_we, load_addr, load_w, load_x, start, len, hold,
        input  W_out, X_out, en_out, acc_clr_n, busy, done
    );

    modport slave (
        input  load_we, load_addr, load_w, load_x, start, len, hold,
        output W_out, X_out, en_out, acc_clr_n, busy, done
    );
endinterface

// File: rtl/neuron_feeder.sv
// Sequencer that clears a neuron accumulator and streams stored (W,X) pairs into it.
// Handshake: start is a one-cycle request taken only when busy=0; done pulses once per run.
module neuron_feeder #(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    neuron_feeder_if.slave bus,
    output logic [2:0] fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [AW-1:0]       idx, idx_d;
    logic [LW-1:0]       cnt, cnt_d;
    logic [LW-1:0]       len_clamped;
    logic signed [N-1:0] w_d, x_d;
    logic                en_d, clr_n_d;

    logic signed [N-1:0] mem_w [DEPTH];
    logic signed [N-1:0] mem_x [DEPTH];

    assign fsm_state   = state;
    assign len_clamped = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;

    // Vector memories are only writable while idle so a run sees a stable snapshot.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.load_we) begin
            mem_w[bus.load_addr] <= bus.load_w;
            mem_x[bus.load_addr] <= bus.load_x;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        w_d     = bus.W_out;
        x_d     = bus.X_out;
        en_d    = 1'b0;
        clr_n_d = 1'b1;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_d = '0;
                    cnt_d = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLEAR;
                        clr_n_d = 1'b0;
                    end
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                if (!bus.hold) begin
                    w_d   = mem_w[idx];
                    x_d   = mem_x[idx];
                    en_d  = 1'b1;
                    idx_d = idx + AW'(1);
                    cnt_d = cnt - LW'(1);
                    if (cnt == LW'(1)) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are registered from the next-state view so they align with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            bus.W_out     <= '0;
            bus.X_out     <= '0;
            bus.en_out    <= 1'b0;
            bus.acc_clr_n <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            cnt           <= cnt_d;
            bus.W_out     <= w_d;
            bus.X_out     <= x_d;
            bus.en_out    <= en_d;
            bus.acc_clr_n <= clr_n_d;
            bus.busy      <= (state_d != IDLE);
            bus.done      <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_neuron_feeder.sv
// Randomized self-checking bench for neuron_feeder against a cycle-timeline reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_neuron_feeder;
    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fsm_state;

    neuron_feeder_if #(.N(N), .DEPTH(DEPTH)) bus ();

    neuron_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [N-1:0] mw [DEPTH];
    logic signed [N-1:0] mx [DEPTH];
    logic [2*N-1:0]      exp_q [$];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int a, input int w, input int x);
        @(negedge clk);
        bus.load_we   = 1'b1;
        bus.load_addr = AW'(a);
        bus.load_w    = N'(w);
        bus.load_x    = N'(x);
        mw[a]         = N'(w);
        mx[a]         = N'(x);
        @(negedge clk);
        bus.load_we   = 1'b0;
    endtask

    // hold_mode: 0 none, 1 random, 2 held in cycles 3..5.  inject: mid-run write + start.
    task automatic run_pass(input int len_v, input int hold_mode, input bit inject,
                            output logic signed [31:0] acc_obs);
        int                  n, d, last, dcyc;
        bit                  hp [256];
        bit                  een [256];
        logic signed [31:0]  exp_acc;
        logic [2*N-1:0]      exp_p;
        logic signed [N-1:0] ew, ex;

        n = (len_v > DEPTH) ? DEPTH : len_v;
        for (int k = 0; k < 256; k++) begin
            een[k] = 1'b0;
            case (hold_mode)
                1:       hp[k] = ($urandom_range(0, 3) == 0);
                2:       hp[k] = (k >= 3 && k <= 5);
                default: hp[k] = 1'b0;
            endcase
        end
        exp_acc = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({mw[i], mx[i]});
            exp_acc += mw[i] * mx[i];
        end
        // Cycle 1 is the clear; pairs are taken on edges from cycle 2 unless held.
        if (n == 0) begin
            dcyc = 1;
        end else begin
            d = 0;
            last = 0;
            for (int k = 2; k < 250 && d < n; k++) begin
                if (!hp[k]) begin
                    d++;
                    een[k+1] = 1'b1;
                    last = k;
                end
            end
            dcyc = last + 2;
        end

        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        bus.start = 1'b1;
        bus.len   = LW'(len_v);
        bus.hold  = hp[0];
        acc_obs   = 0;
        for (int k = 1; k <= dcyc; k++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.load_we = 1'b0;
            check("en_out", bus.en_out, een[k]);
            check("acc_clr_n", bus.acc_clr_n, (n > 0 && k == 1) ? 0 : 1);
            check("busy", bus.busy, 1);
            check("done", bus.done, (k == dcyc) ? 1 : 0);
            if (bus.en_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("extra_pair", 1, 0);
                end else begin
                    exp_p = exp_q.pop_front();
                    ew = exp_p[2*N-1:N];
                    ex = exp_p[N-1:0];
                    check("w_out", bus.W_out, ew);
                    check("x_out", bus.X_out, ex);
                    acc_obs += bus.W_out * bus.X_out;
                end
            end
            bus.hold = hp[k];
            if (inject && k == 2) begin
                bus.load_we   = 1'b1;
                bus.load_addr = '0;
                bus.load_w    = N'($urandom);
                bus.load_x    = N'($urandom);
                bus.start     = 1'b1;
                bus.len       = LW'(1);
            end
        end
        bus.hold = 1'b0;
        check("pairs_left", exp_q.size(), 0);
        exp_q.delete();
        check("acc", acc_obs, exp_acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, bus.en_out, 0);
        check({tag, "_clr_n"}, bus.acc_clr_n, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_w"}, bus.W_out, 0);
        check({tag, "_x"}, bus.X_out, 0);
    endtask

    logic signed [31:0] acc;

    initial begin
        rst           = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_w    = '0;
        bus.load_x    = '0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.hold      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Positive products: 64*2 + 64*2
        load_word(0, 64, 2);
        load_word(1, 64, 2);
        run_pass(2, 0, 0, acc);
        check("s1_acc", acc, 256);

        // Mixed signs: -3*2 + 5*-4
        load_word(0, -3, 2);
        load_word(1, 5, -4);
        run_pass(2, 0, 0, acc);
        check("s2_acc", acc, -26);

        for (int i = 0; i < 4; i++) load_word(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        run_pass(4, 2, 0, acc);

        run_pass(0, 0, 0, acc);
        for (int i = 0; i < DEPTH; i++) load_word(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        run_pass(DEPTH + 3, 0, 0, acc);

        // Ignored write/start while busy, then an immediate restart after DONE.
        run_pass(3, 0, 1, acc);
        run_pass(2, 0, 0, acc);

        // Asynchronous reset in the middle of a stream.
        load_word(0, 64, 2);
        load_word(1, 64, 2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LW'(4);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_en", bus.en_out, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("held_reset");
        rst = 1'b1;
        run_pass(2, 0, 0, acc);
        check("s6_acc", acc, 256);

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_word(int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            end
            run_pass(int'($urandom_range(0, DEPTH + 8)), 1, 1'($urandom_range(0, 1)), acc);
        end

        @(negedge clk);
        check("final_idle", bus.busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
